data_mem_arbiter: RTL
=====================

Name: data_mem_arbiter

Overview:
- Shares one single-port 4096x32 on-chip data memory between two Avalon-MM style masters (m0, m1), e.g. CPU data master and a DMA engine.
- Arbitrates round-robin with at most one access granted per cycle, and drives the memory's address/byteenable/chipselect/write/writedata.
- Tracks the memory's fixed 1-cycle read latency and returns read data to the owning master with readdatavalid.
- Sits between the interconnect masters and the data memory slave.

Parameters:
- ADDR_W, 12, word address width (4096 words).
- DATA_W, 32, data width.
- BE_W, 4, byteenable width (DATA_W/8).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset.
- freeze  in  1  when high, no new grants; in-flight read still completes.
- m0_address  in  ADDR_W  master 0 word address.
- m0_byteenable  in  BE_W  master 0 byte lanes.
- m0_read  in  1  master 0 read request.
- m0_write  in  1  master 0 write request.
- m0_writedata  in  DATA_W  master 0 write data.
- m0_waitrequest  out  1  master 0 must hold request.
- m0_readdata  out  DATA_W  master 0 read data.
- m0_readdatavalid  out  1  master 0 read data valid.
- m1_address, m1_byteenable, m1_read, m1_write, m1_writedata  in  (as m0)  master 1 request.
- m1_waitrequest, m1_readdata, m1_readdatavalid  out  (as m0)  master 1 response.
- mem_address  out  ADDR_W  memory address.
- mem_byteenable  out  BE_W  memory byte lanes.
- mem_chipselect  out  1  memory access this cycle.
- mem_write  out  1  memory write strobe.
- mem_writedata  out  DATA_W  memory write data.
- mem_readdata  in  DATA_W  memory q (valid 1 cycle after address).

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Clock port is clk, reset port is reset_n.
- Request: reqX = mX_read | mX_write. If both read and write are high, the request is a write.
- Arbitration is combinational each cycle:
  - grant only if freeze=0;
  - with a single requester, it wins;
  - with both requesting, the master indicated by the priority pointer prio wins (0 means m0 first).
- prio register: on a granted access it moves to the other master. With no grant it holds. Reset value is 0.
- mX_waitrequest = reqX & ~grantX, combinational. It is 0 when not requesting. A granted access completes in the grant cycle, and the master may present a new request on the next cycle.
- Memory drive during a grant:
  - mem_chipselect=1;
  - mem_write=1 for a write;
  - address, byteenable and writedata muxed from the winner.
- Memory drive with no grant: mem_chipselect=0, mem_write=0, and mem_address/byteenable/writedata hold the m0 inputs (don't-care, no X).
- Read return:
  - registers rd_pend (1 bit) and rd_owner (1 bit) capture (grant & read, winner) each cycle;
  - mX_readdatavalid = rd_pend & (rd_owner==X), registered, so data arrives exactly 1 cycle after the grant cycle;
  - mX_readdata = mem_readdata to both masters; only valid when readdatavalid is high.
- Throughput: back-to-back reads are allowed, 1 per cycle. A read grant followed by a write grant the next cycle is legal (the single-port RAM returns the prior read address data).
- freeze asserted:
  - no grant, so both requesting masters see waitrequest=1;
  - the readdatavalid of a read granted in the previous cycle still fires;
  - prio holds.
- Reset values: prio=0, rd_pend=0, rd_owner=0, m0/m1_readdatavalid=0. Waitrequests follow inputs combinationally.
- Reset asserted mid-read: the pending readdatavalid is cleared and never delivered.
- Fairness: under continuous contention, grants alternate m0, m1, m0, ...; the maximum wait for either master is 1 cycle.

Test Plan:
- Reset, single read: m0 reads addr 0x010 (mem preloaded 0xDEADBEEF) -> grant cycle 0, m0_waitrequest=0, m0_readdatavalid=1 with 0xDEADBEEF at cycle 1, m1_readdatavalid=0.
- Contention: both masters read continuously (m0 addr 0x001, m1 addr 0x002) from reset -> grants m0,m1,m0,m1; waitrequest alternates; each readdatavalid pulses every other cycle with the correct data.
- Byte write: m1 writes 0x11223344, byteenable 4'b0011, to addr 0xFFF (held 0xAAAAAAAA), then m1 reads 0xFFF -> read returns 0xAAAA3344 one cycle after the read grant.
- Freeze: freeze=1 for 3 cycles while both masters request, one cycle after an m0 read grant -> m0 readdatavalid still fires, no mem_chipselect during freeze, both waitrequests high, prio unchanged.
- Reset mid-operation: assert reset_n=0 in the cycle after an m1 read grant -> m1_readdatavalid stays 0; after release prio=0, so m0 wins the first contended cycle.
- Read+write simultaneous on m0 with m1 idle -> treated as a write (mem_write=1), no readdatavalid follows.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares one single-port data memory between two
// Avalon-MM style masters with round-robin arbitration, one access per cycle,
// and returns 1-cycle-latency read data to the master that issued the read.
module data_mem_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              freeze,
  // master 0
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  // master 1
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  // memory
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata
);

  // Priority pointer: 0 means m0 wins a contended cycle, 1 means m1 wins.
  logic r_prio;
  // Read issued last cycle and which master owns the returning data.
  logic r_rd_pend;
  logic r_rd_owner;

  logic w_req0;
  logic w_req1;
  logic w_grant0;
  logic w_grant1;
  logic w_any_grant;
  logic w_rd_grant;

  assign w_req0      = m0_read | m0_write;
  assign w_req1      = m1_read | m1_write;
  assign w_any_grant = w_grant0 | w_grant1;

  // Round-robin arbitration; freeze blocks every new grant.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (freeze) begin
      w_grant0 = 1'b0;
      w_grant1 = 1'b0;
    end else if (w_req0 && w_req1) begin
      if (r_prio == 1'b0) begin
        w_grant0 = 1'b1;
      end else begin
        w_grant1 = 1'b1;
      end
    end else if (w_req0) begin
      w_grant0 = 1'b1;
    end else if (w_req1) begin
      w_grant1 = 1'b1;
    end else begin
      w_grant0 = 1'b0;
      w_grant1 = 1'b0;
    end
  end

  // Memory port mux: m1 fields only when m1 wins, otherwise m0 fields pass through.
  always_comb begin
    mem_address    = m0_address;
    mem_byteenable = m0_byteenable;
    mem_writedata  = m0_writedata;
    if (w_grant1) begin
      mem_address    = m1_address;
      mem_byteenable = m1_byteenable;
      mem_writedata  = m1_writedata;
    end else begin
      mem_address    = m0_address;
      mem_byteenable = m0_byteenable;
      mem_writedata  = m0_writedata;
    end
  end

  // Write wins over read when a master raises both strobes.
  assign mem_chipselect = w_any_grant;
  assign mem_write      = (w_grant0 & m0_write) | (w_grant1 & m1_write);
  assign w_rd_grant     = (w_grant0 & m0_read & ~m0_write) |
                          (w_grant1 & m1_read & ~m1_write);

  assign m0_waitrequest = w_req0 & ~w_grant0;
  assign m1_waitrequest = w_req1 & ~w_grant1;

  // Priority pointer hands priority to the other master after every grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prio <= 1'b0;
    end else if (w_any_grant) begin
      r_prio <= w_grant0;
    end else begin
      r_prio <= r_prio;
    end
  end

  // Track the single outstanding read so its data is steered one cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_pend  <= 1'b0;
      r_rd_owner <= 1'b0;
    end else begin
      r_rd_pend  <= w_rd_grant;
      r_rd_owner <= w_grant1;
    end
  end

  assign m0_readdatavalid = r_rd_pend & ~r_rd_owner;
  assign m1_readdatavalid = r_rd_pend &  r_rd_owner;
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;

endmodule
